game_scoreboard: RTL
====================

// Module: game_scoreboard
// PURPOSE
//  Downstream consumer of main_counter's winner/loser flags. Counts rising edges of each
//  flag and declares game over when either tally reaches WIN_TARGET. Holds the result for
//  OVER_CYCLES, then pulses game_init, which drives main_counter.init to start a new round.
// PARAMETERS
//  CNT_W        4    width of each tally
//  WIN_TARGET   15   tally value that ends the game (1 .. 2**CNT_W-1)
//  OVER_CYCLES  4    cycles gameover is held before restart (>=1)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  winner        in   1      from main_counter; level, may stay high several cycles
//  loser         in   1      from main_counter; level, may stay high several cycles
//  game_init     out  1      one-cycle restart pulse to main_counter.init
//  gameover      out  1      high while a finished game's result is shown
//  who           out  2      00 none, 10 winner side won, 01 loser side won, 11 tie
//  winner_count  out  CNT_W  winner tally
//  loser_count   out  CNT_W  loser tally
// BEHAVIOUR
//  - Reset (async assert, sync release): state PLAY; all outputs 0; edge-detect regs 0.
//  - Event: winner_ev = winner & ~winner_d, with winner_d the flag registered each clk.
//    Same for loser. The d-regs update in every state, so a flag held high through restart
//    is not counted again.
//  - FSM states PLAY, OVER, RESTART (all registered; outputs registered):
//    PLAY: on winner_ev, winner_count+1 at that edge; same for loser_ev. Both events in one
//      cycle increment both tallies. If a new tally == WIN_TARGET, then at the same edge:
//      gameover<=1; who<= 10 (winner only), 01 (loser only) or 11 (both); hold_cnt<=0;
//      go to OVER.
//    OVER: tallies, who and gameover frozen. Events are ignored but edge regs still track.
//      hold_cnt increments each cycle. After OVER_CYCLES cycles in OVER: gameover<=0,
//      who<=00, both tallies<=0, game_init<=1, go to RESTART.
//    RESTART: one cycle only. game_init<=0; go to PLAY. Events in this cycle are ignored.
//  - Latency: flag rise sampled at edge N -> tally updated after edge N. The terminating
//    event sets gameover after edge N. gameover stays high for exactly OVER_CYCLES cycles,
//    then game_init is high for exactly 1 cycle.
//  - Tallies never wrap: game over fires at WIN_TARGET, before 2**CNT_W-1 can overflow.
//  - rst_n low mid-game: everything clears immediately (async). No game_init is emitted.
//  - Unreachable state encodings return to PLAY with outputs cleared.
// STRUCTURE
//  - Package game_pkg:
//    - typedef enum logic [1:0] {PLAY, OVER, RESTART} game_state_t
//    - localparams WHO_NONE=2'b00, WHO_WIN=2'b10, WHO_LOSE=2'b01, WHO_TIE=2'b11
//  - Sub-module rise_detect (clk, rst_n, d, rise): instantiated twice, for winner and loser.
//  - Top level holds the FSM, both tallies and hold_cnt ($clog2(OVER_CYCLES+1) bits).
// TESTING
//  (bench WIN_TARGET=3, OVER_CYCLES=4; scoreboard outputs drive main_counter.init in the
//   integrated bench)
//  1 Reset: rst_n=0 asserted mid-clock -> all outputs 0 before the next edge; after
//    release, state PLAY.
//  2 Held flag: winner high 5 cycles -> winner_count=1 only; loser_count=0; gameover=0.
//  3 Winner wins: 3 separate winner pulses -> after 3rd: winner_count=3, gameover=1,
//    who=10; 4 cycles later gameover=0, who=00, counts=0, game_init=1 for 1 cycle.
//  4 Tie: tallies 2/2, then winner and loser rise in the same cycle -> counts 3/3,
//    gameover=1, who=11.
//  5 Ignored events: loser pulses during OVER and RESTART -> loser_count unchanged,
//    then 0 after restart. A loser held high across RESTART is not counted in PLAY.
//  6 Reset in OVER: rst_n pulse while gameover=1 -> immediate clear; game_init never
//    pulses; then normal counting resumes.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module : game_pkg
//  Brief  : Shared types and constants for the game scoreboard.
//           game_state_t - scoreboard FSM states
//           WHO_*        - encodings of the 'who' result field
//  Rev    : 1.0  initial release
// ============================================================================
package game_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    OVER    = 2'd1,
    RESTART = 2'd2
  } game_state_t;

  // Bit 1 flags the winner side, bit 0 the loser side, so a tie sets both.
  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_WIN  = 2'b10;
  localparam logic [1:0] WHO_LOSE = 2'b01;
  localparam logic [1:0] WHO_TIE  = 2'b11;

endpackage : game_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
//  Module : rise_detect
//  Brief  : Rising-edge detector for a level flag. The previous value of the
//           flag is registered every cycle; rise is high combinationally in
//           the cycle where d is 1 and the registered copy is still 0.
//  Ports  : clk   in  1  rising-edge clock
//           rst_n in  1  asynchronous active-low reset
//           d     in  1  level flag
//           rise  out 1  d & ~d_registered
//  Rev    : 1.0  initial release
// ============================================================================
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/game_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module : game_scoreboard
//  Brief  : Counts rising edges of the winner/loser flags. When either tally
//           reaches WIN_TARGET the result is shown for OVER_CYCLES cycles,
//           then a one-cycle game_init pulse restarts the round.
//  Ports  : clk           in  1      rising-edge clock
//           rst_n         in  1      asynchronous active-low reset
//           winner        in  1      winner level flag
//           loser         in  1      loser level flag
//           game_init     out 1      one-cycle restart pulse
//           gameover      out 1      high while the result is shown
//           who           out 2      00 none, 10 winner, 01 loser, 11 tie
//           winner_count  out CNT_W  winner tally
//           loser_count   out CNT_W  loser tally
//  Rev    : 1.0  initial release
// ============================================================================
module game_scoreboard
  import game_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int WIN_TARGET  = 15,
  parameter int OVER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winner,
  input  logic             loser,
  output logic             game_init,
  output logic             gameover,
  output logic [1:0]       who,
  output logic [CNT_W-1:0] winner_count,
  output logic [CNT_W-1:0] loser_count
);

  localparam int               HOLD_W    = $clog2(OVER_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TARGET    = CNT_W'(WIN_TARGET);

  logic winner_ev;
  logic loser_ev;

  // The edge registers run in every state, so a flag held high across the
  // restart never produces a second event.
  rise_detect u_winner_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (winner),
    .rise  (winner_ev)
  );

  rise_detect u_loser_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (loser),
    .rise  (loser_ev)
  );

  game_state_t       state_q,        state_d;
  logic [CNT_W-1:0]  winner_count_q, winner_count_d;
  logic [CNT_W-1:0]  loser_count_q,  loser_count_d;
  logic [HOLD_W-1:0] hold_cnt_q,     hold_cnt_d;
  logic              gameover_q,     gameover_d;
  logic [1:0]        who_q,          who_d;
  logic              game_init_q,    game_init_d;

  logic [CNT_W-1:0]  winner_inc;
  logic [CNT_W-1:0]  loser_inc;
  logic              win_hit;
  logic              lose_hit;

  always_comb begin
    winner_inc = winner_count_q + CNT_W'(1);
    loser_inc  = loser_count_q + CNT_W'(1);
    win_hit    = winner_ev && (winner_inc == TARGET);
    lose_hit   = loser_ev && (loser_inc == TARGET);

    state_d        = state_q;
    winner_count_d = winner_count_q;
    loser_count_d  = loser_count_q;
    hold_cnt_d     = hold_cnt_q;
    gameover_d     = gameover_q;
    who_d          = who_q;
    game_init_d    = game_init_q;

    case (state_q)
      PLAY: begin
        if (winner_ev) winner_count_d = winner_inc;
        if (loser_ev)  loser_count_d  = loser_inc;
        if (win_hit || lose_hit) begin
          gameover_d = 1'b1;
          // {winner, loser} hit bits line up with the WHO_* encodings.
          who_d      = {win_hit, lose_hit};
          hold_cnt_d = '0;
          state_d    = OVER;
        end
      end

      OVER: begin
        // hold_cnt counts the OVER cycles already elapsed; leaving on the
        // OVER_CYCLES-th edge keeps gameover up for exactly OVER_CYCLES cycles.
        if (hold_cnt_q == HOLD_LAST) begin
          gameover_d     = 1'b0;
          who_d          = WHO_NONE;
          winner_count_d = '0;
          loser_count_d  = '0;
          game_init_d    = 1'b1;
          state_d        = RESTART;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      RESTART: begin
        game_init_d = 1'b0;
        state_d     = PLAY;
      end

      default: begin
        state_d        = PLAY;
        winner_count_d = '0;
        loser_count_d  = '0;
        hold_cnt_d     = '0;
        gameover_d     = 1'b0;
        who_d          = WHO_NONE;
        game_init_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= PLAY;
      winner_count_q <= '0;
      loser_count_q  <= '0;
      hold_cnt_q     <= '0;
      gameover_q     <= 1'b0;
      who_q          <= WHO_NONE;
      game_init_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      winner_count_q <= winner_count_d;
      loser_count_q  <= loser_count_d;
      hold_cnt_q     <= hold_cnt_d;
      gameover_q     <= gameover_d;
      who_q          <= who_d;
      game_init_q    <= game_init_d;
    end
  end

  assign game_init    = game_init_q;
  assign gameover     = gameover_q;
  assign who          = who_q;
  assign winner_count = winner_count_q;
  assign loser_count  = loser_count_q;

endmodule : game_scoreboard
`default_nettype wire
